dcache_store_buffer: RTL and testbench



---
 rtl/dcache_store_buffer.sv | 141 ++++++++++++++
 tb/tb_dcache_store_buffer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/dcache_store_buffer.sv
// dcache_store_buffer: in-order store FIFO drained as single-beat AXI writes, with a load address-hazard check.
// Define STORE_MERGE_EN to merge same-word stores into the tail entry.
module dcache_store_buffer #(
  parameter int DEPTH = 8,
  parameter int ADDR_W = 32,
  parameter int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  output logic              rd_hazard,
  output logic              sb_empty,
  output logic              wr_err,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);
  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;
  state_t r_state;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [31:0] r_data [DEPTH];
  logic [3:0] r_strb [DEPTH];
  logic [DEPTH_BITS-1:0] r_wp, r_rp, w_widx;
  logic [DEPTH_BITS:0] r_cnt;
  logic w_full, w_merge, w_push, w_alloc, w_pop, w_we, w_hit, w_unused;
  logic [31:0] w_wdata, w_hdata;
  logic [3:0] w_wstrb, w_hstrb;
  assign w_full = r_cnt == (DEPTH_BITS+1)'(DEPTH);
`ifdef STORE_MERGE_EN
  logic [DEPTH_BITS-1:0] w_tail;
  logic [31:0] w_mdata;
  assign w_tail = r_wp - DEPTH_BITS'(1);
  assign w_merge = (r_cnt != '0) && (r_addr[w_tail][ADDR_W-1:2] == s_awaddr[ADDR_W-1:2]) &&
                   (r_cnt > (DEPTH_BITS+1)'(1) || r_state == IDLE);
  always_comb begin
    w_mdata = r_data[w_tail];
    for (int b = 0; b < 4; b++)
      if (s_wstrb[b]) w_mdata[8*b +: 8] = s_wdata[8*b +: 8];
  end
  assign s_awready = ~w_full | w_merge;
  assign w_we = w_alloc | (w_push & w_merge);
  assign w_widx = w_merge ? w_tail : r_wp;
  assign w_wdata = w_merge ? w_mdata : s_wdata;
  assign w_wstrb = w_merge ? (r_strb[w_tail] | s_wstrb) : s_wstrb;
  // a merge into a lone idle entry must also reach the beat latched on this same edge
  assign w_hdata = (w_push & w_merge & (r_cnt == (DEPTH_BITS+1)'(1))) ? w_wdata : r_data[r_rp];
  assign w_hstrb = (w_push & w_merge & (r_cnt == (DEPTH_BITS+1)'(1))) ? w_wstrb : r_strb[r_rp];
`else
  assign w_merge = 1'b0;
  assign s_awready = ~w_full;
  assign w_we = w_alloc;
  assign w_widx = r_wp;
  assign w_wdata = s_wdata;
  assign w_wstrb = s_wstrb;
  assign w_hdata = r_data[r_rp];
  assign w_hstrb = r_strb[r_rp];
`endif
  assign s_wready = s_awready;
  assign w_push = s_awvalid & s_wvalid & s_awready;
  assign w_alloc = w_push & (|s_wstrb) & ~w_merge;
  assign w_pop = (r_state == RESP) & m_bvalid;
  assign m_wlast = 1'b1;
  assign sb_empty = (r_cnt == '0) && (r_state == IDLE);
  assign rd_hazard = rd_valid & w_hit;
  assign w_unused = ^rd_addr[1:0];
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (({1'b0, DEPTH_BITS'(DEPTH_BITS'(i) - r_rp)} < r_cnt) && (r_addr[i][ADDR_W-1:2] == rd_addr[ADDR_W-1:2]))
        w_hit = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_data[w_widx] <= w_wdata;
      r_strb[w_widx] <= w_wstrb;
    end
    if (w_alloc) r_addr[r_wp] <= s_awaddr;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_alloc) r_wp <= r_wp + DEPTH_BITS'(1);
      if (w_pop) r_rp <= r_rp + DEPTH_BITS'(1);
      r_cnt <= r_cnt + (DEPTH_BITS+1)'(w_alloc) - (DEPTH_BITS+1)'(w_pop);
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      m_awaddr <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
      m_awvalid <= 1'b0;
      m_wvalid <= 1'b0;
      m_bready <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (r_cnt != '0) begin
          m_awaddr <= r_addr[r_rp];
          m_wdata <= w_hdata;
          m_wstrb <= w_hstrb;
          m_awvalid <= 1'b1;
          m_wvalid <= 1'b1;
          r_state <= SEND;
        end
        SEND: begin
          m_awvalid <= m_awvalid & ~m_awready;
          m_wvalid <= m_wvalid & ~m_wready;
          if ((~m_awvalid | m_awready) & (~m_wvalid | m_wready)) begin
            m_bready <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: if (m_bvalid) begin
          m_bready <= 1'b0;
          wr_err <= wr_err | (m_bresp != 2'b00);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dcache_store_buffer.sv
// tb_dcache_store_buffer: randomized AXI/CPU traffic checked against a queue-based store-buffer model.
module tb_dcache_store_buffer;
  localparam int DEPTH = 8;
  logic clk = 1'b0, reset;
  logic [31:0] s_awaddr, s_wdata, rd_addr, m_awaddr, m_wdata;
  logic [3:0] s_wstrb, m_wstrb;
  logic [1:0] m_bresp;
  logic s_awvalid, s_awready, s_wvalid, s_wready, rd_valid, rd_hazard, sb_empty, wr_err;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] s;} ent_t;
  ent_t q[$];
  bit inflight, aw_seen, w_seen, err;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  dcache_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_hazard(rd_hazard), .sb_empty(sb_empty), .wr_err(wr_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit merge_ok(input logic [31:0] a);
`ifdef STORE_MERGE_EN
    return q.size() > 0 && q[q.size()-1].a[31:2] == a[31:2] && (q.size() > 1 || !inflight);
`else
    return a == 32'hFFFF_FFFF && 1'b0;
`endif
  endfunction
  function automatic bit hazard(input logic [31:0] a);
    foreach (q[i]) if (q[i].a[31:2] == a[31:2]) return 1'b1;
    return 1'b0;
  endfunction
  task automatic idle_inputs();
    s_awvalid = 0; s_wvalid = 0; s_awaddr = 0; s_wdata = 0; s_wstrb = 0;
    rd_valid = 1; rd_addr = 32'h100; m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
  endtask
  task automatic do_reset();
    idle_inputs();
    reset = 1;
    #1;
    chk("rst_awvalid", m_awvalid, 0); chk("rst_wvalid", m_wvalid, 0); chk("rst_bready", m_bready, 0);
    chk("rst_awaddr", m_awaddr, 0); chk("rst_wdata", m_wdata, 0); chk("rst_wstrb", m_wstrb, 0);
    chk("rst_s_awready", s_awready, 1); chk("rst_s_wready", s_wready, 1); chk("rst_empty", sb_empty, 1);
    chk("rst_hazard", rd_hazard, 0); chk("rst_wr_err", wr_err, 0);
    q.delete(); inflight = 0; aw_seen = 0; w_seen = 0; err = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask
  task automatic step(input int pp, input int pa, input int pw);
    bit push, mg, pre_busy;
    int t;
    @(negedge clk);
    chk("awvalid", m_awvalid, inflight && !aw_seen);
    chk("wvalid", m_wvalid, inflight && !w_seen);
    chk("bready", m_bready, aw_seen && w_seen);
    chk("sb_empty", sb_empty, q.size() == 0);
    chk("wr_err", wr_err, err);
    chk("wlast", m_wlast, 1);
    s_awvalid = ($urandom % 100) < pp;
    s_wvalid = s_awvalid ? ($urandom % 8 != 0) : ($urandom % 8 == 0);
    s_awaddr = 32'h100 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
    s_wdata = $urandom;
    s_wstrb = ($urandom % 5 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    rd_valid = $urandom % 4 != 0;
    rd_addr = 32'h100 + 4 * $urandom_range(0, 8) + $urandom_range(0, 3);
    m_awready = ($urandom % 100) < pa;
    m_wready = ($urandom % 100) < pw;
    m_bvalid = aw_seen && w_seen && ($urandom % 2 == 0);
    m_bresp = ($urandom % 8 == 0) ? 2'b10 : 2'b00;
    #1;
    chk("s_awready", s_awready, q.size() < DEPTH || merge_ok(s_awaddr));
    chk("s_wready", s_wready, q.size() < DEPTH || merge_ok(s_awaddr));
    chk("rd_hazard", rd_hazard, rd_valid && hazard(rd_addr));
    mg = merge_ok(s_awaddr);
    push = s_awvalid && s_wvalid && (q.size() < DEPTH || mg);
    pre_busy = q.size() > 0;
    if (m_awvalid && m_awready) begin
      chk("aw_dup", aw_seen, 0);
      if (q.size() > 0) chk("aw_addr", m_awaddr, q[0].a);
      aw_seen = 1;
    end
    if (m_wvalid && m_wready) begin
      chk("w_dup", w_seen, 0);
      if (q.size() > 0) begin
        chk("w_data", m_wdata, q[0].d);
        chk("w_strb", m_wstrb, q[0].s);
      end
      w_seen = 1;
    end
    if (m_bvalid && m_bready) begin
      if (m_bresp != 2'b00) err = 1;
      if (q.size() > 0) void'(q.pop_front());
      inflight = 0; aw_seen = 0; w_seen = 0;
    end else if (!inflight && pre_busy) inflight = 1;
    if (push && mg) begin
      t = q.size() - 1;
      for (int b = 0; b < 4; b++) if (s_wstrb[b]) q[t].d[8*b +: 8] = s_wdata[8*b +: 8];
      q[t].s = q[t].s | s_wstrb;
    end else if (push && s_wstrb != 0) q.push_back('{s_awaddr, s_wdata, s_wstrb});
  endtask
  initial begin
    int n;
    do_reset();
    repeat (300) step(60, 80, 80);
    repeat (40) step(90, 0, 50);
    repeat (300) step(50, 30, 30);
    repeat (200) step(70, 90, 90);
    @(negedge clk);
    do_reset();
    repeat (200) step(50, 70, 70);
    n = 0;
    while (q.size() > 0 && n < 300) begin
      step(0, 100, 100);
      n++;
    end
    @(negedge clk);
    chk("drained", sb_empty, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
